// File: rtl/ps2_color_entry_ctrl.sv
// PS/2 scancode decoder and 3-digit hex color entry controller.
// Turns the raw scancode byte stream into key actions (make/break, E0 prefix), sequences a
// 12-bit hex color entry with backspace, escape and an inactivity timeout, and delivers the
// committed color over a valid/ready handshake.
// Optional feature: define KEY_REPEAT_FILTER_EN to drop typematic repeats of a held key.
module ps2_color_entry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [11:0] color_out,
  output logic        color_valid,
  input  logic        color_ready,
  output logic [1:0]  digit_count,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {DIdle, DExt, DBrk, DExtBrk} dec_state_e;
  typedef enum logic {StEntry, StCommit} entry_state_e;

  dec_state_e   dec_q, dec_d;
  entry_state_e st_q, st_d;
  logic [11:0]  acc_q, acc_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [11:0]  color_q, color_d;
  logic         err_q, err_d;
  logic [31:0]  tmo_q, tmo_d;

  logic       is_make, is_break, fwd;
  logic [4:0] dig;
  logic       key_digit, key_enter, key_bksp, key_esc, key_any;

  // Prefix decoder: classifies each received byte as make, break or prefix.
  always_comb begin
    dec_d    = dec_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    if (rx_valid) begin
      unique case (dec_q)
        DIdle: begin
          if (rx_data == 8'hF0)      dec_d = DBrk;
          else if (rx_data == 8'hE0) dec_d = DExt;
          else                       is_make = 1'b1;
        end
        DExt: begin
          if (rx_data == 8'hF0) begin
            dec_d = DExtBrk;
          end else begin
            dec_d   = DIdle;
            // Keypad Enter is the only extended key we care about.
            is_make = (rx_data == 8'h5A);
          end
        end
        DBrk, DExtBrk: begin
          is_break = 1'b1;
          dec_d    = DIdle;
        end
        default: dec_d = DIdle;
      endcase
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic [7:0] held_q, held_d;

  // Held-key filter: a make matching the held key is a typematic repeat.
  always_comb begin
    held_d = held_q;
    fwd    = 1'b0;
    if (is_make) begin
      if (rx_data != held_q) begin
        held_d = rx_data;
        fwd    = 1'b1;
      end
    end else if (is_break && (rx_data == held_q)) begin
      held_d = 8'h00;
    end
  end

  // Held-key register.
  always_ff @(posedge clk) begin
    if (rst) held_q <= 8'h00;
    else     held_q <= held_d;
  end
`else
  logic unused_break;
  assign unused_break = is_break;
  assign fwd          = is_make;
`endif

  // Key map: {hit, value} for hex digits, plus command decodes.
  always_comb begin
    case (rx_data)
      8'h70:   dig = 5'h10;
      8'h69:   dig = 5'h11;
      8'h72:   dig = 5'h12;
      8'h7A:   dig = 5'h13;
      8'h6B:   dig = 5'h14;
      8'h73:   dig = 5'h15;
      8'h74:   dig = 5'h16;
      8'h6C:   dig = 5'h17;
      8'h75:   dig = 5'h18;
      8'h7D:   dig = 5'h19;
      8'h1C:   dig = 5'h1A;
      8'h32:   dig = 5'h1B;
      8'h21:   dig = 5'h1C;
      8'h23:   dig = 5'h1D;
      8'h24:   dig = 5'h1E;
      8'h2B:   dig = 5'h1F;
      default: dig = 5'h00;
    endcase
  end

  assign key_digit = fwd & dig[4];
  assign key_enter = fwd & (rx_data == 8'h5A);
  assign key_bksp  = fwd & (rx_data == 8'h66);
  assign key_esc   = fwd & (rx_data == 8'h76);
  assign key_any   = key_digit | key_enter | key_bksp | key_esc;

  // Entry FSM and inactivity timeout.
  always_comb begin
    logic edit;
    st_d    = st_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    err_d   = 1'b0;
    tmo_d   = tmo_q;
    edit    = 1'b0;
    unique case (st_q)
      StEntry: begin
        if (key_digit) begin
          if (cnt_q != 2'd3) begin
            acc_d = {acc_q[7:0], dig[3:0]};
            cnt_d = cnt_q + 2'd1;
            edit  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_bksp) begin
          if (cnt_q != 2'd0) begin
            acc_d = acc_q >> 4;
            cnt_d = cnt_q - 2'd1;
            edit  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_esc) begin
          acc_d = 12'h000;
          cnt_d = 2'd0;
          edit  = 1'b1;
        end else if (key_enter) begin
          if (cnt_q != 2'd0) begin
            color_d = acc_q;
            acc_d   = 12'h000;
            cnt_d   = 2'd0;
            st_d    = StCommit;
          end else begin
            err_d = 1'b1;
          end
        end
        // An accepted edit in the expiry cycle wins and restarts the count.
        if (edit || (st_d == StCommit) || (cnt_q == 2'd0)) begin
          tmo_d = 32'd0;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TIMEOUT_CYCLES - 1)) begin
          acc_d = 12'h000;
          cnt_d = 2'd0;
          tmo_d = 32'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StCommit: begin
        // Keys are evaluated against COMMIT even in the handshake cycle.
        err_d = key_any;
        tmo_d = 32'd0;
        if (color_ready) st_d = StEntry;
      end
      default: st_d = StEntry;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= DIdle;
      st_q    <= StEntry;
      acc_q   <= 12'h000;
      cnt_q   <= 2'd0;
      color_q <= 12'hFFF;
      err_q   <= 1'b0;
      tmo_q   <= 32'd0;
    end else begin
      dec_q   <= dec_d;
      st_q    <= st_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign color_out   = color_q;
  assign color_valid = (st_q == StCommit);
  assign busy        = (st_q == StCommit);
  assign digit_count = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_color_entry_ctrl.sv
// Self-checking bench for ps2_color_entry_ctrl (TIMEOUT_CYCLES = 16).
// Expected commits are queued when Enter is driven and compared when color_valid rises.
module tb_ps2_color_entry_ctrl;

`ifdef KEY_REPEAT_FILTER_EN
  localparam bit Filter = 1'b1;
`else
  localparam bit Filter = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [11:0] color_out;
  logic        color_valid;
  logic        color_ready;
  logic [1:0]  digit_count;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  ps2_color_entry_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .color_out  (color_out),
    .color_valid(color_valid),
    .color_ready(color_ready),
    .digit_count(digit_count),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every rising color_valid must match the oldest queued commit.
  initial begin
    logic prev_valid;
    logic [11:0] exp;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (color_valid === 1'b1 && prev_valid === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected: color_out=%h but no commit was expected", color_out);
        end else begin
          exp = exp_q.pop_front();
          if (color_out !== exp) begin
            errors++;
            $display("FAIL commit_color: got %h expected %h", color_out, exp);
          end
        end
      end
      prev_valid = color_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive one byte for one cycle; returns #1 after the edge that consumed it.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic rel(input logic [7:0] b);
    send(8'hF0);
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    color_ready = 1'b1;
    @(posedge clk); #1;
    color_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (color_out !== 12'hFFF) begin errors++; $display("FAIL rst_color: got %h expected fff", color_out); end
    checks++; if (color_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", color_valid); end
    checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", digit_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
  endtask

  task automatic test_basic();
    send(8'h69);
    checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL basic_cnt1: got %0d expected 1", digit_count); end
    rel(8'h69);
    send(8'h1C);
    checks++; if (digit_count !== 2'd2) begin errors++; $display("FAIL basic_cnt2: got %0d expected 2", digit_count); end
    rel(8'h1C);
    send(8'h7D);
    checks++; if (digit_count !== 2'd3) begin errors++; $display("FAIL basic_cnt3: got %0d expected 3", digit_count); end
    rel(8'h7D);
    exp_q.push_back(12'h1A9);
    send(8'h5A);
    checks++; if (color_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", color_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL basic_cnt_clr: got %0d expected 0", digit_count); end
    rel(8'h5A);
    idle(3);
    checks++; if (color_valid !== 1'b1 || color_out !== 12'h1A9) begin
      errors++; $display("FAIL basic_hold: valid=%b color=%h expected 1/1a9", color_valid, color_out);
    end
    ack();
    checks++; if (color_valid !== 1'b0 || color_out !== 12'h1A9) begin
      errors++; $display("FAIL basic_done: valid=%b color=%h expected 0/1a9", color_valid, color_out);
    end
    // Ready with nothing pending is ignored.
    ack();
    checks++; if (color_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle_ready: valid=%b busy=%b expected 0/0", color_valid, busy);
    end
  endtask

  task automatic test_repeat();
    logic [1:0] exp_cnt;
    for (int i = 0; i < 3; i++) begin
      send(8'h72);
      exp_cnt = Filter ? 2'd1 : 2'(i + 1);
      checks++; if (digit_count !== exp_cnt) begin
        errors++; $display("FAIL repeat_cnt%0d: got %0d expected %0d", i, digit_count, exp_cnt);
      end
    end
    rel(8'h72);
    exp_q.push_back(Filter ? 12'h002 : 12'h222);
    send(8'h5A);
    checks++; if (color_valid !== 1'b1) begin errors++; $display("FAIL repeat_valid: got %b expected 1", color_valid); end
    rel(8'h5A);
    ack();
  endtask

  task automatic test_overflow_bksp();
    send(8'h69); rel(8'h69);
    send(8'h72); rel(8'h72);
    send(8'h7A); rel(8'h7A);
    send(8'h6B);
    checks++; if (err !== 1'b1 || digit_count !== 2'd3) begin
      errors++; $display("FAIL ovf_err: err=%b cnt=%0d expected 1/3", err, digit_count);
    end
    idle(1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_pulse: got %b expected 0", err); end
    rel(8'h6B);
    send(8'h66);
    checks++; if (digit_count !== 2'd2 || err !== 1'b0) begin
      errors++; $display("FAIL bksp: cnt=%0d err=%b expected 2/0", digit_count, err);
    end
    rel(8'h66);
    exp_q.push_back(12'h012);
    send(8'h5A);
    rel(8'h5A);
    ack();
    checks++; if (color_out !== 12'h012) begin errors++; $display("FAIL bksp_color: got %h expected 012", color_out); end
  endtask

  task automatic test_empty_ext_commit();
    send(8'h5A);
    checks++; if (err !== 1'b1 || color_valid !== 1'b0) begin
      errors++; $display("FAIL empty_enter: err=%b valid=%b expected 1/0", err, color_valid);
    end
    rel(8'h5A);
    checks++; if (color_valid !== 1'b0) begin errors++; $display("FAIL empty_novalid: got %b expected 0", color_valid); end
    send(8'h74); rel(8'h74);
    send(8'hE0);
    checks++; if (digit_count !== 2'd1 || err !== 1'b0) begin
      errors++; $display("FAIL ext_prefix: cnt=%0d err=%b expected 1/0", digit_count, err);
    end
    exp_q.push_back(12'h006);
    send(8'h5A);
    checks++; if (color_valid !== 1'b1) begin errors++; $display("FAIL ext_valid: got %b expected 1", color_valid); end
    send(8'hE0); rel(8'h5A);
    send(8'h73);
    checks++; if (err !== 1'b1 || color_out !== 12'h006 || color_valid !== 1'b1) begin
      errors++; $display("FAIL commit_reject: err=%b color=%h valid=%b expected 1/006/1", err, color_out, color_valid);
    end
    rel(8'h73);
    // Key in the same cycle as handshake completion is still rejected.
    color_ready = 1'b1;
    send(8'h73);
    color_ready = 1'b0;
    checks++; if (err !== 1'b1 || color_valid !== 1'b0 || digit_count !== 2'd0) begin
      errors++; $display("FAIL ready_coincide: err=%b valid=%b cnt=%0d expected 1/0/0", err, color_valid, digit_count);
    end
    rel(8'h73);
  endtask

  task automatic test_timeout();
    send(8'h75); rel(8'h75);
    idle(13);
    checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL tmo_early: got %0d expected 1", digit_count); end
    idle(1);
    checks++; if (digit_count !== 2'd0 || err !== 1'b0) begin
      errors++; $display("FAIL tmo_expire: cnt=%0d err=%b expected 0/0", digit_count, err);
    end
    // Digit arriving in the expiry cycle wins and restarts the count.
    send(8'h75); rel(8'h75);
    idle(13);
    send(8'h73);
    checks++; if (digit_count !== 2'd2) begin errors++; $display("FAIL tmo_coincide: got %0d expected 2", digit_count); end
    rel(8'h73);
    idle(13);
    checks++; if (digit_count !== 2'd2) begin errors++; $display("FAIL tmo_restart: got %0d expected 2", digit_count); end
    idle(1);
    checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL tmo_expire2: got %0d expected 0", digit_count); end
    send(8'h75); rel(8'h75);
    idle(8);
    send(8'h76);
    checks++; if (digit_count !== 2'd0 || err !== 1'b0) begin
      errors++; $display("FAIL escape: cnt=%0d err=%b expected 0/0", digit_count, err);
    end
    rel(8'h76);
  endtask

  task automatic test_reset_mid();
    send(8'h74); rel(8'h74);
    exp_q.push_back(12'h006);
    send(8'h5A);
    rel(8'h5A);
    pulse_rst();
    checks++; if (color_out !== 12'hFFF || color_valid !== 1'b0 || busy !== 1'b0 ||
                  digit_count !== 2'd0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_commit: color=%h valid=%b busy=%b cnt=%0d err=%b expected fff/0/0/0/0",
                         color_out, color_valid, busy, digit_count, err);
    end
    send(8'hE0);
    pulse_rst();
    checks++; if (color_out !== 12'hFFF || color_valid !== 1'b0 || digit_count !== 2'd0) begin
      errors++; $display("FAIL rst_prefix: color=%h valid=%b cnt=%0d expected fff/0/0",
                         color_out, color_valid, digit_count);
    end
    send(8'h74);
    checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL rst_prefix_idle: got %0d expected 1", digit_count); end
    rel(8'h74);
    exp_q.push_back(12'h006);
    send(8'h5A);
    checks++; if (color_valid !== 1'b1 || color_out !== 12'h006) begin
      errors++; $display("FAIL rst_recommit: valid=%b color=%h expected 1/006", color_valid, color_out);
    end
    rel(8'h5A);
    ack();
  endtask

  initial begin
    rst         = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    color_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_repeat();
    test_overflow_bksp();
    test_empty_ext_commit();
    test_timeout();
    test_reset_mid();
    idle(2);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL commits_missing: %0d expected commits never seen, 0 required", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
